permutation_ctrl: RTL
=====================

# permutation_ctrl

Sequencer for the ASCON permutation rounds: captures a 320-bit state, drives the round index into the combinational round datapath (constant addition, substitution, linear diffusion), and registers that datapath's result once per cycle. Each run executes rounds start..11. The result is returned through a valid/ready handshake. The block sits between the mode FSM (initialization, associated data, plaintext, finalization) and the round datapath. It provides p12 (start 0), p8 (start 4) and p6 (start 6) under one interface.

## Interface
- No parameters. State type is `t_state_array` from `ascon_pkg`: 5 lanes × 64 bits. The round index is 4 bits, valid 0..11.
- `clock`  in  1  single clock; all flops rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  start request; sampled only while `o_ready`=1.
- `i_start_round`  in  4  first round index; legal 0..11.
- `i_state`  in  t_state_array  state loaded on an accepted start.
- `i_abort`  in  1  synchronous abort; returns to IDLE.
- `i_round_state`  in  t_state_array  datapath output for (`o_state`, `o_round`).
- `o_round`  out  4  current round index to the datapath (= round_q).
- `o_state`  out  t_state_array  registered state (state_q); feeds the datapath and the consumer.
- `o_ready`  out  1  start can be accepted this cycle.
- `o_busy`  out  1  FSM in RUN.
- `o_valid`  out  1  `o_state` holds a finished permutation result.
- `i_ready`  in  1  consumer accepts the result.
- `o_err`  out  1  one-cycle pulse: start rejected because `i_start_round` > 11.

## Operation
- FSM states:
  - IDLE: default after reset.
  - RUN: one round per cycle.
  - DONE: result held until accepted.
- `o_ready` = IDLE | (DONE & `i_ready`).
- Accepted start means `i_start` & `o_ready` & `i_start_round` ≤ 11. On an accepted start:
  - state_q ← `i_state`
  - round_q ← `i_start_round`
  - next state is RUN.
- `i_start` & `o_ready` with `i_start_round` > 11:
  - nothing is loaded;
  - `o_err`=1 for the next cycle;
  - IDLE is kept, or IDLE is entered if the rejection happens in DONE & `i_ready`.
- Each RUN cycle:
  - state_q ← `i_round_state`;
  - if round_q = 11, next state is DONE and round_q holds at 11;
  - otherwise round_q ← round_q + 1.
- Round count per run is N = 12 − start round: 12 for p12, 8 for p8, 6 for p6.
- DONE:
  - `o_valid`=1; state_q and round_q are held.
  - `i_ready`=1 with no accepted start: next state is IDLE.
  - `i_ready`=1 with an accepted start in the same cycle: back-to-back, next state is RUN with the new load.
  - `i_ready`=0: stay in DONE. `o_state` is stable, and `i_start` is ignored.
- `i_start` during RUN is ignored. There is no queuing.
- `i_abort` has the highest synchronous priority:
  - next state is IDLE and round_q ← 0;
  - state_q is held;
  - a start in the same cycle is dropped and `o_err` is not raised.
- Arithmetic: round_q is a 4-bit register and never exceeds 11. No other wrap-around exists.

## Timing
- Reset (async, immediate) sets:
  - FSM = IDLE, state_q = 0, round_q = 0;
  - `o_ready`=1, `o_busy`=0, `o_valid`=0, `o_err`=0, `o_round`=0, `o_state`=0.
- All outputs are registered or decoded from the FSM register. There is no combinational path from any input to `o_valid`, `o_busy`, `o_round` or `o_state`.
- `o_ready` depends combinationally on `i_ready` only.
- Start accepted at edge k:
  - RUN during cycles k..k+N−1, with `o_round` = s..11;
  - `o_valid` rises after edge k+N.
- Latency from start edge to `o_valid` is N cycles: p12 = 12, p8 = 8, p6 = 6.
- Handshake completes on the edge where `o_valid` & `i_ready`. Back-to-back runs have zero idle cycles.
- Reset asserted mid-run clears everything immediately. After reset deasserts, the block behaves as fresh from IDLE.

## Test plan
- Reset mid-RUN (p12, round 5) → all outputs return to reset values immediately. A p6 start after release produces `o_valid` 6 cycles later.
- p12 on `i_state` = NIST init vector (key/nonce all 0x00..0F) → `o_round` steps 0..11 and `o_valid` appears exactly 12 cycles after the start edge. `o_state` matches the reference-model p12 output; `o_busy`=1 for exactly 12 cycles.
- p6 start with `i_ready`=0 for 5 cycles after `o_valid` → `o_state` is stable and `i_start` is ignored throughout. The result is accepted on the first `i_ready`=1 edge.
- DONE & `i_ready` & `i_start` with `i_start_round`=4 → next cycle is RUN, `o_round`=4, with no idle cycle. The second result arrives 8 cycles later.
- `i_start` with `i_start_round`=12 in IDLE → `o_err` pulses 1 cycle, FSM stays IDLE, state_q is unchanged. Start round 15 behaves the same.
- `i_abort` at RUN round 7 → IDLE next cycle, `o_round`=0, state_q holds the round-7 value, `o_valid` never asserts. A simultaneous `i_start` is dropped.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared types for the ASCON permutation blocks.
// State is five 64-bit lanes, lane 0 in [0].
package ascon_pkg;
    typedef logic [4:0][63:0] t_state_array;
endpackage

// File: rtl/permutation_ctrl.sv
// Round sequencer for the ASCON permutation (p12 / p8 / p6).
// Loads a state, steps rounds start..11, then holds the result.
module permutation_ctrl
    import ascon_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         i_start,
    input  logic [3:0]   i_start_round,
    input  t_state_array i_state,
    input  logic         i_abort,
    input  t_state_array i_round_state,
    output logic [3:0]   o_round,
    output t_state_array o_state,
    output logic         o_ready,
    output logic         o_busy,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_err
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } t_fsm;

    t_fsm         r_fsm;
    logic [3:0]   r_round;
    t_state_array r_state;
    logic         r_err;

    logic w_ready;
    logic w_start_ok;

    assign w_ready    = (r_fsm == S_IDLE) | ((r_fsm == S_DONE) & i_ready);
    assign w_start_ok = i_start & w_ready & (i_start_round <= 4'd11);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fsm   <= S_IDLE;
            r_round <= '0;
            r_state <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            // Abort outranks everything, including a same-cycle start.
            if (i_abort) begin
                r_fsm   <= S_IDLE;
                r_round <= '0;
            end else begin
                case (r_fsm)
                    S_RUN: begin
                        r_state <= i_round_state;
                        if (r_round == 4'd11)
                            r_fsm <= S_DONE;
                        else
                            r_round <= r_round + 4'd1;
                    end
                    S_IDLE, S_DONE: begin
                        if (w_start_ok) begin
                            r_state <= i_state;
                            r_round <= i_start_round;
                            r_fsm   <= S_RUN;
                        end else if (w_ready) begin
                            r_fsm <= S_IDLE;
                            r_err <= i_start;
                        end
                    end
                    default: r_fsm <= S_IDLE;
                endcase
            end
        end
    end

    assign o_round = r_round;
    assign o_state = r_state;
    assign o_ready = w_ready;
    assign o_busy  = (r_fsm == S_RUN);
    assign o_valid = (r_fsm == S_DONE);
    assign o_err   = r_err;
endmodule
